// File: rtl/div_16x8_restoring_seq.sv
// Sequential 16/8 unsigned restoring divider: one quotient bit per clock, 16 CALC cycles.
// A zero divisor skips CALC and reports quotient=16'hFFFF with div_by_zero set.
module div_16x8_restoring_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] dividend,
    input  logic [7:0]  divisor,
    output logic        busy,
    output logic        done,
    output logic [15:0] quotient,
    output logic [7:0]  remainder,
    output logic        div_by_zero
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t      state;
    state_t      state_nxt;

    // Quotient bits enter at the LSB as dividend bits leave the MSB, so one
    // register holds the remaining dividend above and the growing quotient below.
    logic [15:0] work_shreg;
    logic [7:0]  divisor_reg;
    logic [7:0]  partial;
    logic [4:0]  count;

    logic [8:0]  shifted;
    logic        fits;
    logic [7:0]  partial_nxt;
    logic [15:0] work_nxt;

    // The compare is done at 9 bits; the difference always fits in 8 bits
    // because the partial remainder stays below the divisor.
    always_comb begin
        shifted     = {partial, work_shreg[15]};
        fits        = (shifted >= {1'b0, divisor_reg});
        partial_nxt = fits ? (shifted[7:0] - divisor_reg) : shifted[7:0];
        work_nxt    = {work_shreg[14:0], fits};
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (divisor == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (count == 5'd1) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            work_shreg  <= '0;
            divisor_reg <= '0;
            partial     <= '0;
            count       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= '0;
                            div_by_zero <= 1'b1;
                        end else begin
                            work_shreg  <= dividend;
                            divisor_reg <= divisor;
                            partial     <= '0;
                            count       <= 5'd16;
                            div_by_zero <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    work_shreg <= work_nxt;
                    partial    <= partial_nxt;
                    count      <= count - 5'd1;
                    if (count == 5'd1) begin
                        quotient  <= work_nxt;
                        remainder <= partial_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_div_16x8_restoring_seq.sv
// Scoreboard bench for div_16x8_restoring_seq: the driver queues expected results,
// the monitor pops and checks them whenever done is seen.
module tb_div_16x8_restoring_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] dividend = '0;
    logic [7:0]  divisor = '0;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_by_zero;

    div_16x8_restoring_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] q;
        logic [7:0]  r;
        logic        dbz;
        int unsigned lat;
        int unsigned issued;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int unsigned errors = 0;
    int unsigned checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // Waits for IDLE, presents one start cycle and optionally queues the expected result.
    task automatic issue(input logic [15:0] a, input logic [7:0] b, input bit expect_it,
                         input logic [15:0] eq, input logic [7:0] er);
        int unsigned n = 0;
        exp_t e;
        @(negedge clk);
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("idle_timeout", 32'd1, 32'd0);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        if (expect_it) begin
            e.q      = eq;
            e.r      = er;
            e.dbz    = (b == 8'd0);
            e.lat    = (b == 8'd0) ? 1 : 17;
            e.issued = cyc;
            sb.push_back(e);
        end
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_drain();
        int unsigned n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) chk("drain_timeout", sb.size(), 32'd0);
    endtask

    initial begin
        bit   prev_done = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (done) begin
                chk("done_single_cycle", {31'd0, prev_done}, 32'd0);
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("quotient", {16'd0, quotient}, {16'd0, e.q});
                    chk("remainder", {24'd0, remainder}, {24'd0, e.r});
                    chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dbz});
                    chk("latency", cyc - e.issued, e.lat);
                    chk("busy_with_done", {31'd0, busy}, 32'd1);
                end
            end
            prev_done = done;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [7:0]  a8;
        logic [7:0]  b8;
        logic [15:0] p16;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_quotient", {16'd0, quotient}, 32'd0);
        chk("reset_remainder", {24'd0, remainder}, 32'd0);
        chk("reset_dbz", {31'd0, div_by_zero}, 32'd0);
        rst_n = 1'b1;

        issue(16'd1000, 8'd7, 1'b1, 16'd142, 8'd6);
        wait_drain();
        repeat (4) @(negedge clk);
        chk("hold_quotient", {16'd0, quotient}, 32'd142);
        chk("hold_remainder", {24'd0, remainder}, 32'd6);
        chk("idle_busy", {31'd0, busy}, 32'd0);

        issue(16'hFFFF, 8'h01, 1'b1, 16'hFFFF, 8'd0);
        issue(16'hFFFF, 8'hFF, 1'b1, 16'd257, 8'd0);
        issue(16'h1234, 8'h00, 1'b1, 16'hFFFF, 8'd0);
        wait_drain();
        repeat (3) @(negedge clk);
        chk("hold_dbz", {31'd0, div_by_zero}, 32'd1);
        issue(16'd1000, 8'd7, 1'b1, 16'd142, 8'd6);
        issue(16'd0, 8'd5, 1'b1, 16'd0, 8'd0);
        issue(16'd5, 8'd10, 1'b1, 16'd0, 8'd5);
        issue(16'd65025, 8'd255, 1'b1, 16'd255, 8'd0);
        issue(16'd65535, 8'd16, 1'b1, 16'd4095, 8'd15);
        issue(16'd12345, 8'd123, 1'b1, 16'd100, 8'd45);
        issue(16'd7, 8'd7, 1'b1, 16'd1, 8'd0);
        issue(16'd0, 8'd0, 1'b1, 16'hFFFF, 8'd0);
        issue(16'd255, 8'd2, 1'b1, 16'd127, 8'd1);
        issue(16'd40000, 8'd200, 1'b1, 16'd200, 8'd0);
        issue(16'd1, 8'd255, 1'b1, 16'd0, 8'd1);
        wait_drain();

        // start pulses with altered operands while the division is busy
        issue(16'd1000, 8'd7, 1'b1, 16'd142, 8'd6);
        repeat (2) @(negedge clk);
        dividend = 16'hABCD;
        divisor  = 8'd0;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        dividend = 16'd9999;
        divisor  = 8'd3;
        repeat (6) @(negedge clk);
        start    = 1'b1;
        divisor  = 8'd1;
        @(negedge clk);
        start    = 1'b0;
        wait_drain();
        repeat (20) @(negedge clk);
        chk("ignored_start_idle", {31'd0, busy}, 32'd0);

        // reset in the middle of CALC, with a coincident start
        issue(16'd1000, 8'd7, 1'b0, 16'd0, 8'd0);
        repeat (8) @(negedge clk);
        rst_n    = 1'b0;
        start    = 1'b1;
        dividend = 16'd100;
        divisor  = 8'd9;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        start = 1'b0;
        @(negedge clk);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_quotient", {16'd0, quotient}, 32'd0);
        chk("abort_remainder", {24'd0, remainder}, 32'd0);
        chk("abort_dbz", {31'd0, div_by_zero}, 32'd0);
        repeat (20) @(negedge clk);
        chk("abort_stays_idle", {31'd0, busy}, 32'd0);
        issue(16'd5, 8'd3, 1'b1, 16'd1, 8'd2);
        wait_drain();

        // a*b divided by b must give a exactly, back-to-back
        for (int i = 0; i < 200; i++) begin
            a8  = 8'($urandom_range(0, 255));
            b8  = 8'($urandom_range(1, 255));
            p16 = 16'(a8) * 16'(b8);
            issue(p16, b8, 1'b1, 16'(a8), 8'd0);
        end
        for (int i = 0; i < 200; i++) begin
            p16 = 16'($urandom_range(0, 65535));
            b8  = 8'($urandom_range(0, 255));
            if (b8 == 8'd0) issue(p16, b8, 1'b1, 16'hFFFF, 8'd0);
            else issue(p16, b8, 1'b1, p16 / 16'(b8), 8'(p16 % 16'(b8)));
        end
        wait_drain();
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
